ring_nic: RTL
=============

# ring_nic

Network interface controller between one `cmp` core's data-memory port and its ring router. The core sees four 64-bit memory-mapped registers: an input channel buffer, an output channel buffer and their status words. The router side uses a send/ready handshake with virtual-channel polarity gating. There is one instance per node, downstream of each core's `addr_out`/`d_out`/`memEn`/`memWrEn` outputs in the four-node CMP.

## Interface
Parameters:
- `PKT_W`, 64: packet and data width.
- `ADDR_W`, 2: register-select width, taken from the low bits of the core's address.

Ports:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, `reset`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  [0:1]  register select.
- `d_in`  in  [0:63]  core write data.
- `d_out`  out  [0:63]  core read data.
- `nicEn`  in  1  access strobe.
- `nicWrEn`  in  1  1 = write, 0 = read; qualified by `nicEn`.
- `net_si`  in  1  router presents a packet to the NIC.
- `net_ri`  out  1  NIC can accept a packet.
- `net_di`  in  [0:63]  incoming packet.
- `net_so`  out  1  NIC sends a packet.
- `net_ro`  in  1  router can accept a packet.
- `net_do`  out  [0:63]  outgoing packet.
- `net_polarity`  in  1  router's current virtual-channel phase.

## Operation
Register map, indexed by `addr`:
- `2'b00` input buffer: read-only. A read returns the buffered packet and clears the input status on the next edge.
- `2'b01` input status: read-only. Reads as `{63'b0, in_full}`, with the flag at bit 63.
- `2'b10` output buffer: write-only. A write when not full loads `d_in` and sets `out_full`. A write when full is dropped with no state change.
- `2'b11` output status: read-only. Reads as `{63'b0, out_full}`.
- Writes to read-only addresses are ignored.
- Reads of `2'b10` return 0.
- `d_out` is 0 when `nicEn` is 0.

Input channel:
- `net_ri = ~in_full`.
- On an edge with `net_si & net_ri`, the buffer captures `net_di` and `in_full` becomes 1.
- A read of `00` with `in_full` = 0 returns stale data and has no effect.

Output channel:
- `net_do` shows the head packet.
- `net_so = out_full & net_ro & (net_do[0] == net_polarity)`. Bit 0 of the packet is its VC bit.
- On an edge with `net_so` = 1, the head is consumed and `out_full` clears.
- Every output-side condition is evaluated in the same cycle; there is no retry state.

Simultaneous events:
- A core write to `10` on the same edge as `net_so` consuming the head: the write is dropped, because full is sampled before the edge. The core must poll `11`.
- A core read of `00` while `in_full` = 1: `net_ri` stays 0 that cycle and rises the next cycle.

Reset values:
- `in_full` and `out_full` = 0.
- Both data registers = 0.
- `net_so` = 0, `net_ri` = 1, `d_out` = 0.
- Reset mid-transfer discards both buffered packets.

## Timing
- Reads are combinational: `d_out` is valid in the same cycle as `nicEn`/`addr`, which matches the core's memory read timing.
- All state updates on the rising edge of `clk`.
- Router to core latency: a packet accepted at edge N is readable from cycle N+1, and `01` reads 1 in cycle N+1.
- Core to router latency: a write at edge N makes `net_so` eligible in cycle N+1.
- Injection then waits for the first cycle with `net_ro` = 1 and a matching polarity.
- Throughput with a single-entry output buffer: at most one packet every 2 cycles per direction. Polarity further limits this to the cycles where the VC bit matches.

## Configuration
Macro `RING_NIC_OUTQ2_EN`:
- Defined: the output channel is a 2-entry FIFO.
  - `out_full` means 2 entries; status `11` reads 1 only when both slots are occupied.
  - `net_so` uses the head slot.
  - A write and a send on the same edge with 1 entry stored both succeed; the count stays at 1.
  - With 2 entries stored, a write is dropped even if a send happens on the same edge.
- Undefined: a single-entry buffer as described above.
- The input channel is unaffected either way.

## Structure
- Package `ring_nic_pkg`:
  - `PKT_W`.
  - `VC_BIT` = 0.
  - Register address constants `NIC_IN_BUF`, `NIC_IN_STAT`, `NIC_OUT_BUF`, `NIC_OUT_STAT`.
- Sub-module `nic_chan_buf`:
  - A one-entry data register plus full flag, with load/consume strobes.
  - Instantiated once for input, and once or twice for output (twice for the FIFO under the macro).
- Top-level `ring_nic` contains address decode, read mux and handshake gating.

## Test plan
- Reset, then idle: `net_ri` = 1, `net_so` = 0, and reads of `01` and `11` return 0.
- Write `64'h0000_0000_0000_00A5` to `10` with `net_polarity` = 0 and `net_ro` = 1 → `net_so` = 1 the next cycle with `net_do` = that value; `11` reads 0 after the send edge.
- Same write with `net_do[0]` = 1 and `net_polarity` = 0 → `net_so` stays 0 until the polarity toggles to 1, then fires for one cycle.
- Drive `net_si` with `64'hDEAD_BEEF_0000_0001` → `net_ri` drops the next cycle and `01` reads 1. A read of `00` returns the packet, and `net_ri` = 1 one cycle later.
- With `net_ro` = 0, issue two writes (0x11, then 0x22) → the second is dropped and the later send carries 0x11. Under `RING_NIC_OUTQ2_EN`, both are sent in order.
- Assert `reset` while both buffers are full → the next cycle `net_ri` = 1, `net_so` = 0, and both status reads return 0.

Source files
------------

// File: rtl/ring_nic_pkg.sv
// Shared constants for the ring NIC register map and output queue depth.
// Build option: define RING_NIC_OUTQ2_EN for a 2-entry output FIFO.
package ring_nic_pkg;

    localparam int PKT_W  = 64;
    localparam int VC_BIT = 0;

    typedef enum logic [1:0] {
        NIC_IN_BUF   = 2'b00,
        NIC_IN_STAT  = 2'b01,
        NIC_OUT_BUF  = 2'b10,
        NIC_OUT_STAT = 2'b11
    } nic_reg_e;

`ifdef RING_NIC_OUTQ2_EN
    localparam int OUT_DEPTH = 2;
`else
    localparam int OUT_DEPTH = 1;
`endif

    // Status words carry their flag in the last (least significant) bit.
    function automatic logic [0:PKT_W-1] status_word(input logic flag);
        return {{(PKT_W-1){1'b0}}, flag};
    endfunction

endpackage

// File: rtl/ring_nic_if.sv
// Core-side register bus and router-side send/ready channel of one ring NIC.
interface ring_nic_if #(
    parameter int PKT_W  = 64,
    parameter int ADDR_W = 2
);
    logic [0:ADDR_W-1] addr;
    logic [0:PKT_W-1]  d_in;
    logic [0:PKT_W-1]  d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_si;
    logic              net_ri;
    logic [0:PKT_W-1]  net_di;
    logic              net_so;
    logic              net_ro;
    logic [0:PKT_W-1]  net_do;
    logic              net_polarity;

    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/ring_nic_chan_buf.sv
// One-entry packet register with a full flag; a load takes priority over a consume.
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [0:W-1] load_data,
    input  logic         consume,
    output logic [0:W-1] data,
    output logic         full
);
    logic [0:W-1] data_reg;
    logic         full_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= '0;
            full_reg <= 1'b0;
        end else if (load) begin
            data_reg <= load_data;
            full_reg <= 1'b1;
        end else if (consume) begin
            full_reg <= 1'b0;
        end
    end

    assign data = data_reg;
    assign full = full_reg;
endmodule

// File: rtl/ring_nic.sv
// Ring NIC top: register decode, combinational read mux and router handshake gating.
// Build option: RING_NIC_OUTQ2_EN turns the output buffer into a 2-entry FIFO.
module ring_nic
    import ring_nic_pkg::*;
#(
    parameter int PKT_W  = ring_nic_pkg::PKT_W,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    ring_nic_if.slave  nic
);
    nic_reg_e         reg_sel;
    logic             rd_en;
    logic             wr_en;
    logic             in_load;
    logic             in_consume;
    logic             in_full;
    logic [0:PKT_W-1] in_data;
    logic             out_full;
    logic             wr_ok;
    logic             send;
    logic [0:PKT_W-1] rd_data;

    logic [0:PKT_W-1] slot_data      [OUT_DEPTH];
    logic [0:PKT_W-1] slot_load_data [OUT_DEPTH];
    logic             slot_full      [OUT_DEPTH];
    logic             slot_load      [OUT_DEPTH];
    logic             slot_consume   [OUT_DEPTH];

    assign reg_sel = nic_reg_e'(nic.addr[ADDR_W-2 +: 2]);
    assign rd_en   = nic.nicEn & ~nic.nicWrEn;
    assign wr_en   = nic.nicEn & nic.nicWrEn;

    // Input channel: a core read of the buffer frees it on the following edge.
    assign in_load    = nic.net_si & ~in_full;
    assign in_consume = rd_en & (reg_sel == NIC_IN_BUF) & in_full;
    assign nic.net_ri = ~in_full;

    nic_chan_buf #(.W(PKT_W)) u_in_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (in_load),
        .load_data (nic.net_di),
        .consume   (in_consume),
        .data      (in_data),
        .full      (in_full)
    );

    // Output channel: full is sampled before the edge, so a write racing a send is dropped when full.
    assign wr_ok      = wr_en & (reg_sel == NIC_OUT_BUF) & ~out_full;
    assign send       = slot_full[0] & nic.net_ro & (slot_data[0][VC_BIT] == nic.net_polarity);
    assign nic.net_so = send;
    assign nic.net_do = slot_data[0];

    always_comb begin
        for (int i = 0; i < OUT_DEPTH; i++) begin
            slot_load[i]      = 1'b0;
            slot_load_data[i] = nic.d_in;
            slot_consume[i]   = 1'b0;
        end
`ifdef RING_NIC_OUTQ2_EN
        out_full = slot_full[0] & slot_full[1];
        // Head refills from the tail when it advances, else takes the new write.
        slot_load[0]      = (wr_ok & (~slot_full[0] | send)) | (send & slot_full[1]);
        slot_load_data[0] = slot_full[1] ? slot_data[1] : nic.d_in;
        slot_consume[0]   = send;
        slot_load[1]      = wr_ok & slot_full[0] & ~send;
        slot_consume[1]   = send;
`else
        out_full          = slot_full[0];
        slot_load[0]      = wr_ok;
        slot_consume[0]   = send;
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_out_slot
            nic_chan_buf #(.W(PKT_W)) u_slot (
                .clk       (clk),
                .reset     (reset),
                .load      (slot_load[gi]),
                .load_data (slot_load_data[gi]),
                .consume   (slot_consume[gi]),
                .data      (slot_data[gi]),
                .full      (slot_full[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (nic.nicEn) begin
            case (reg_sel)
                NIC_IN_BUF:   rd_data = in_data;
                NIC_IN_STAT:  rd_data = status_word(in_full);
                NIC_OUT_BUF:  rd_data = '0;
                NIC_OUT_STAT: rd_data = status_word(out_full);
                default:      rd_data = '0;
            endcase
        end
    end

    assign nic.d_out = rd_data;
endmodule
